// File: rtl/spr_arb_pkg.sv
// Shared types and helpers for the two-master SPR Wishbone arbiter.
package spr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  function automatic logic [1:0] onehot_gnt(arb_state_e state);
    case (state)
      OWN0:    return 2'b01;
      OWN1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/spr_arb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags expiry on the last one.
module spr_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = (TIMEOUT_CYCLES != 0) && run && !clear && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear || !run || expire) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spr_bus_arbiter_2x1.sv
// Round-robin 2:1 Wishbone arbiter for the SPR target path; grant held for the CYC tenure.
module spr_bus_arbiter_2x1
  import spr_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  output logic                    m0_ack,
  output logic                    m0_err,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_w,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic [DATA_WIDTH-1:0]   s_dat_r,
  input  logic                    s_ack,
  input  logic                    s_err,
  output logic [1:0]              gnt,
  output logic                    timeout
);

  arb_state_e state_q, state_d;
  owner_t     last_q, last_d;

  logic req0, req1;
  logic own_cyc, own_stb;
  logic wd_run, wd_clear, wd_expire;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_q == 1'b1)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc) state_d = IDLE;
      OWN1:    if (!m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Watchdog sees the master's raw strobe so the forced s_stb drop cannot feed back.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    if (state_q == OWN0) begin
      own_cyc = m0_cyc;
      own_stb = m0_stb;
    end else if (state_q == OWN1) begin
      own_cyc = m1_cyc;
      own_stb = m1_stb;
    end
    wd_run   = (state_q != IDLE) && own_stb && !s_ack && !s_err;
    wd_clear = (state_q == IDLE) || !own_stb || s_ack || s_err;
  end

  spr_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rstn  (rstn),
    .run   (wd_run),
    .clear (wd_clear),
    .expire(wd_expire)
  );

  always_comb begin
    s_cyc    = own_cyc & ~wd_expire;
    s_stb    = own_stb & ~wd_expire;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_w  = '0;
    s_sel    = '0;
    m0_dat_r = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_dat_r = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    case (state_q)
      OWN0: begin
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_w  = m0_dat_w;
        s_sel    = m0_sel;
        m0_dat_r = s_dat_r;
        m0_ack   = s_ack;
        m0_err   = s_err | wd_expire;
      end
      OWN1: begin
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_w  = m1_dat_w;
        s_sel    = m1_sel;
        m1_dat_r = s_dat_r;
        m1_ack   = s_ack;
        m1_err   = s_err | wd_expire;
      end
      default: ;
    endcase
    gnt     = onehot_gnt(state_q);
    timeout = wd_expire;
  end

endmodule

// File: tb/tb_spr_bus_arbiter_2x1.sv
// Directed self-checking bench for spr_bus_arbiter_2x1 (watchdog shortened to 8 cycles).
module tb_spr_bus_arbiter_2x1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;
  logic [1:0]  gnt;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spr_bus_arbiter_2x1 #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_w(m0_dat_w), .m0_sel(m0_sel), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt), .timeout(timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0; m1_sel = '0;
    s_dat_r = '0; s_ack = 0; s_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    step();
    step();
    #2 rstn = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1234; s_ack = 1;
    step();
    step();
    n_checks++;
    if ({gnt, s_cyc, s_stb, timeout, m0_ack, m0_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000", {gnt, s_cyc, s_stb, timeout, m0_ack, m0_err});
    end
    n_checks++;
    if (s_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_adr: got %h required 00000000", s_adr);
    end
    idle_inputs();
    #2 rstn = 1;
    step();
  endtask

  task automatic test_contention();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    m0_adr = 32'h10; m1_adr = 32'h20;
    #1;
    n_checks++;
    if (gnt !== 2'b00) begin n_fail++; $display("FAIL cont_pre: gnt got %b required 00", gnt); end
    step();
    n_checks++;
    if ({gnt, s_adr} !== {2'b01, 32'h10}) begin
      n_fail++; $display("FAIL cont_first: gnt/adr got %b/%h required 01/00000010", gnt, s_adr);
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    n_checks++;
    if ({gnt, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL cont_idle: gnt/s_cyc got %b/%b required 00/0", gnt, s_cyc);
    end
    step();
    n_checks++;
    if ({gnt, s_adr} !== {2'b10, 32'h20}) begin
      n_fail++; $display("FAIL cont_second: gnt/adr got %b/%h required 10/00000020", gnt, s_adr);
    end
    m1_cyc = 0; m1_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL cont_repeat: gnt got %b required 01", gnt); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h4800; m0_sel = 4'hF;
    step();
    n_checks++;
    if ({gnt, s_cyc, s_stb, s_we, s_adr, s_sel} !== {2'b01, 3'b110, 32'h4800, 4'hF}) begin
      n_fail++; $display("FAIL read_grant: gnt/adr got %b/%h required 01/00004800", gnt, s_adr);
    end
    step();
    step();
    s_ack = 1; s_dat_r = 32'hA5A5_0001;
    #1;
    n_checks++;
    if ({m0_ack, m0_err, m0_dat_r} !== {2'b10, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL read_data: ack/err/dat got %b/%b/%h required 1/0/a5a50001", m0_ack, m0_err, m0_dat_r);
    end
    n_checks++;
    if ({m1_ack, m1_err, m1_dat_r} !== 34'h0) begin
      n_fail++; $display("FAIL read_nonowner: ack/err/dat got %b/%b/%h required 0/0/0", m1_ack, m1_err, m1_dat_r);
    end
    step();
    s_ack = 0; s_dat_r = '0; m0_cyc = 0; m0_stb = 0;
    step();
    n_checks++;
    if ({gnt, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL read_release: gnt/s_cyc got %b/%b required 00/0", gnt, s_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [3];
    adrs[0] = 32'h5000; adrs[1] = 32'h5001; adrs[2] = 32'h5002;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = adrs[0]; m1_dat_w = 32'hD0; m1_sel = 4'h3;
    step();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h77;
    for (int unsigned i = 0; i < 3; i++) begin
      m1_stb = 1; m1_adr = adrs[i]; m1_dat_w = 32'hD0 + i;
      s_ack = 1;
      #1;
      n_checks++;
      if ({gnt, s_stb, s_we, s_adr, s_dat_w} !== {2'b10, 2'b11, adrs[i], 32'hD0 + i}) begin
        n_fail++; $display("FAIL blk_write%0d: gnt/adr/dat got %b/%h/%h required 10/%h/%h",
                           i, gnt, s_adr, s_dat_w, adrs[i], 32'hD0 + i);
      end
      n_checks++;
      if (m1_ack !== 1'b1) begin n_fail++; $display("FAIL blk_ack%0d: got %b required 1", i, m1_ack); end
      step();
      s_ack = 0; m1_stb = 0;
      #1;
      n_checks++;
      if ({gnt, s_cyc, s_stb} !== 4'b1010) begin
        n_fail++; $display("FAIL blk_hold%0d: gnt/cyc/stb got %b/%b/%b required 10/1/0", i, gnt, s_cyc, s_stb);
      end
      step();
    end
    m1_cyc = 0;
    step();
    n_checks++;
    if ({gnt, s_cyc} !== 3'b000) begin
      n_fail++; $display("FAIL blk_idle: gnt/s_cyc got %b/%b required 00/0", gnt, s_cyc);
    end
    step();
    n_checks++;
    if ({gnt, s_adr} !== {2'b01, 32'h77}) begin
      n_fail++; $display("FAIL blk_m0_grant: gnt/adr got %b/%h required 01/00000077", gnt, s_adr);
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_timeout(input logic ack_last);
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4804;
    for (int unsigned i = 1; i <= 8; i++) begin
      step();
      if (i == 8) begin
        s_ack = ack_last;
        #1;
        n_checks++;
        if (ack_last) begin
          if ({m0_ack, m0_err, timeout, s_stb, s_cyc} !== 5'b10011) begin
            n_fail++; $display("FAIL wd_ack_wins: ack/err/to/stb/cyc got %b required 10011",
                               {m0_ack, m0_err, timeout, s_stb, s_cyc});
          end
        end else begin
          if ({m0_ack, m0_err, timeout, s_stb, s_cyc} !== 5'b01100) begin
            n_fail++; $display("FAIL wd_expire: ack/err/to/stb/cyc got %b required 01100",
                               {m0_ack, m0_err, timeout, s_stb, s_cyc});
          end
        end
      end else begin
        n_checks++;
        if ({m0_err, timeout, s_stb} !== 3'b001) begin
          n_fail++; $display("FAIL wd_wait%0d: err/to/stb got %b required 001", i, {m0_err, timeout, s_stb});
        end
      end
    end
    step();
    s_ack = 0;
    #1;
    n_checks++;
    if ({gnt, timeout, m0_err, s_stb} !== 5'b01001) begin
      n_fail++; $display("FAIL wd_after: gnt/to/err/stb got %b required 01001", {gnt, timeout, m0_err, s_stb});
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h6000;
    step();
    n_checks++;
    if (gnt !== 2'b10) begin n_fail++; $display("FAIL arst_pre: gnt got %b required 10", gnt); end
    #2;
    s_ack = 1;
    rstn = 0;
    #1;
    n_checks++;
    if ({gnt, s_cyc, s_stb, m1_ack} !== 5'b0) begin
      n_fail++; $display("FAIL arst_now: gnt/cyc/stb/ack got %b required 00000", {gnt, s_cyc, s_stb, m1_ack});
    end
    idle_inputs();
    step();
    #2 rstn = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    n_checks++;
    if (gnt !== 2'b01) begin n_fail++; $display("FAIL arst_after: gnt got %b required 01", gnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    test_reset();
    test_contention();
    test_single_read();
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spr_bus_arbiter_2x1.md
Name: spr_bus_arbiter_2x1

Overview:
- Round-robin arbiter that shares one 32-bit Wishbone SPR target path between two Wishbone masters.
- Typical masters: the SPR BFM and an interrupt-service sequencer; the target is the SPR interconnect feeding the PIC/TT shims.
- Grants hold for the whole CYC tenure.
- A bus watchdog converts a hung slave into an ERR to the owning master.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- TIMEOUT_CYCLES, 64, cycles STB may wait without ACK/ERR before forced error; 0 disables the watchdog.

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- mN_cyc, mN_stb, mN_we  in  1 each  master N (N=0,1) cycle/strobe/write
- mN_adr  in  ADDR_WIDTH  master N address
- mN_dat_w  in  DATA_WIDTH  master N write data
- mN_sel  in  DATA_WIDTH/8  master N byte selects
- mN_dat_r  out  DATA_WIDTH  read data to master N
- mN_ack, mN_err  out  1 each  termination to master N
- s_cyc, s_stb, s_we  out  1 each  to SPR target
- s_adr  out  ADDR_WIDTH  to SPR target
- s_dat_w  out  DATA_WIDTH  to SPR target
- s_sel  out  DATA_WIDTH/8  to SPR target
- s_dat_r  in  DATA_WIDTH  from SPR target
- s_ack, s_err  in  1 each  from SPR target
- gnt  out  2  one-hot current owner; 00 when idle
- timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, rstn=0): state=IDLE, last_owner=1, watchdog count=0. All outputs 0. Takes effect immediately, including mid-transfer; no termination is issued to the interrupted master.
- States: IDLE, OWN0, OWN1.
- IDLE transitions:
  - Request N = mN_cyc & mN_stb.
  - Exactly one request: go to OWNN.
  - Both requesting: grant the master != last_owner, then update last_owner.
  - Grant is registered: a request first seen at edge k is presented on s_* from cycle k+1 (one-cycle arbitration latency).
- OWNN:
  - s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel are combinational copies of master N.
  - mN_dat_r=s_dat_r, mN_ack=s_ack, mN_err=s_err.
  - The non-owner sees dat_r=0, ack=0, err=0.
- Leaving OWNN:
  - Return to IDLE on the edge where mN_cyc=0.
  - Owner keeping CYC high across several STB phases retains the grant (block/RMW cycles).
  - ACK in the same cycle CYC drops is forwarded, then IDLE.
  - No direct OWN0->OWN1 transition; every tenure passes through IDLE for one cycle.
- In IDLE all s_* outputs are 0 and gnt=00.
- Watchdog:
  - Counts while state!=IDLE, s_stb=1, s_ack=0, s_err=0.
  - Clears on ack, err, stb low, or entering IDLE.
  - When count reaches TIMEOUT_CYCLES-1 with the condition still true:
    - that cycle, mN_err=1, timeout=1, and s_cyc=s_stb=0 are forced;
    - count clears;
    - state stays OWNN until the master drops CYC.
  - A real s_ack arriving in the expiry cycle wins: it is forwarded, no timeout.
- Width rule: count is $clog2(TIMEOUT_CYCLES+1) bits, saturating, with no wrap.

Decomposition:
- Package spr_arb_pkg:
  - arb_state_e (IDLE, OWN0, OWN1);
  - owner_t (1 bit);
  - function onehot_gnt(state).
- One sub-module, spr_arb_watchdog: params TIMEOUT_CYCLES; ports clk, rstn, run, clear, expire. It holds the counter and expiry compare.

Test Plan:
- Single read: m0 reads adr 0x4800, slave acks 2 cycles after s_stb with dat 0xA5A5_0001 -> gnt=01 one cycle after request; m0_dat_r=0xA5A5_0001 with m0_ack; m1 outputs stay 0; gnt=00 after m0_cyc drops.
- Simultaneous requests from reset -> m0 granted first (last_owner=1). After m0 releases: one IDLE cycle, then gnt=10. A repeat contention grants m0 again.
- m1 holds CYC across 3 write strobes (adr 0x5000/0x5001/0x5002) while m0 requests -> all 3 writes reach s_* in order; m0 is granted only after m1_cyc=0 plus one IDLE cycle.
- TIMEOUT_CYCLES=8, slave never acks -> m0_err and timeout pulse exactly in the 8th cycle of s_stb high; s_stb=0 in that cycle; no ack delivered.
- TIMEOUT_CYCLES=8, s_ack in the 8th cycle -> ack forwarded, no err, no timeout pulse.
- rstn asserted while OWN1 mid-transfer -> gnt=00 and s_cyc=0 immediately (asynchronous). After release, a simultaneous request grants m0.
